// File: rtl/loader_pkg.sv
// Shared types and helpers for the Ising model stream loader.
package loader_pkg;

  // Load sequence; ST_CHECK is only reachable when the checksum beat is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WEIGHT,
    ST_HBIAS,
    ST_CONST,
    ST_SCALE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Bit positions inside err_o.
  localparam int ERR_SCALE = 0;
  localparam int ERR_CSUM  = 1;

  // Largest scaling factor the macro can apply.
  localparam int SCALE_MAX = 16;

  // Stream beats needed to fill one J-memory row.
  function automatic int row_beats(input int num_spin, input int bitj, input int data_w);
    return (num_spin * bitj) / data_w;
  endfunction

  // Stream beats needed to fill the h-bias vector.
  function automatic int hb_beats(input int num_spin, input int bith, input int data_w);
    return (num_spin * bith) / data_w;
  endfunction

  // A scaling factor is usable only as a power of two in [1, SCALE_MAX].
  function automatic logic scale_legal(input logic [31:0] v);
    return (v != 32'd0) && (v <= SCALE_MAX) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/row_assembler.sv
// Collects BEATS stream words into a W-bit field, honouring the bit order.
// Little order: beat k fills bits [k*DW +: DW]. Big order: the whole field is
// bit-reversed, so beat k lands reversed at the top end of the field.
module row_assembler #(
  parameter int W     = 16,
  parameter int DW    = 8,
  parameter int BEATS = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          beat_i,
  input  logic          little_i,
  input  logic [DW-1:0] word_i,
  output logic [W-1:0]  data_o,
  output logic          last_o,
  output logic          full_o
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    word_rev;
  logic [IDX_W-1:0] base;
  int               base_int;

  // Bit-reverse the incoming word for big-order placement.
  always_comb begin
    // NOTE: assign a default before the loop so the block stays purely combinational (no latch).
    word_rev = '0;
    for (int b = 0; b < DW; b++) begin
      word_rev[b] = word_i[DW-1-b];
    end
  end

  // Field offset of the current beat in either bit order.
  always_comb begin
    base_int = little_i ? int'(cnt_q) * DW : W - (int'(cnt_q) + 1) * DW;
    base     = IDX_W'(base_int);
  end

  assign last_o = (cnt_q == CNT_W'(BEATS - 1));

  // Beat counter, field placement and one-cycle full pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the field register is reset because it drives a port directly;
    // pure storage arrays elsewhere would be left without reset.
    if (rst_i) begin
      cnt_q  <= '0;
      data_o <= '0;
      full_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      full_o <= beat_i && last_o && !clr_i;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (beat_i) begin
        data_o[base +: DW] <= little_i ? word_i : word_rev;
        cnt_q              <= last_o ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/model_stream_loader.sv
// Loads an Ising model from a valid/ready word stream: J rows go out on the
// memory write port, h-bias/constant/scaling are committed on completion.
// Optional build macro: MODEL_LOADER_CHECKSUM_EN adds a trailing XOR checksum beat.
module model_stream_loader
  import loader_pkg::*;
#(
  parameter int NUM_SPIN    = 256,
  parameter int BITJ        = 4,
  parameter int BITH        = 4,
  parameter int DATA_W      = 64,
  parameter int CONST_W     = 32,
  parameter int SCALING_BIT = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         little_endian_i,
  input  logic [DATA_W-1:0]            s_data_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  output logic                         wr_en_o,
  output logic [$clog2(NUM_SPIN)-1:0]  wr_addr_o,
  output logic [NUM_SPIN*BITJ-1:0]     wr_data_o,
  output logic [NUM_SPIN*BITH-1:0]     hbias_o,
  output logic [CONST_W-1:0]           constant_o,
  output logic [SCALING_BIT-1:0]       scaling_factor_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   err_o
);

  localparam int ROW_W     = NUM_SPIN * BITJ;
  localparam int HB_W      = NUM_SPIN * BITH;
  localparam int ROW_BEATS = row_beats(NUM_SPIN, BITJ, DATA_W);
  localparam int HB_BEATS  = hb_beats(NUM_SPIN, BITH, DATA_W);
  localparam int ADDR_W    = $clog2(NUM_SPIN);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_SPIN - 1);

  if ((ROW_W % DATA_W) != 0 || (HB_W % DATA_W) != 0) begin : g_bad_data_w
    $fatal(1, "model_stream_loader: DATA_W must divide NUM_SPIN*BITJ and NUM_SPIN*BITH");
  end
  if (CONST_W > DATA_W || SCALING_BIT > DATA_W) begin : g_bad_const_w
    $fatal(1, "model_stream_loader: CONST_W and SCALING_BIT must fit in DATA_W");
  end

  state_t                 state;
  logic [ADDR_W-1:0]      row_idx;
  logic                   le_q;
  logic                   hb_valid;
  logic [CONST_W-1:0]     const_sh;
  logic                   accept, start_go, row_last, hb_last, hb_full;
  logic [HB_W-1:0]        hb_data;
  logic [SCALING_BIT-1:0] scale_word;
  logic                   scale_ok_now;
`ifdef MODEL_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]      csum_q;
  logic [SCALING_BIT-1:0] scale_sh;
  logic                   scale_ok_q;
`endif

  // abort_i wins over any beat or start in the same cycle.
  assign accept       = s_valid_i && s_ready_o && !abort_i;
  assign start_go     = (state == ST_IDLE) && start_i && !abort_i;
  assign scale_word   = s_data_i[SCALING_BIT-1:0];
  assign scale_ok_now = scale_legal(32'(scale_word));

  row_assembler #(.W(ROW_W), .DW(DATA_W), .BEATS(ROW_BEATS)) u_row (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (start_go),
    .beat_i   (accept && (state == ST_WEIGHT)),
    .little_i (le_q),
    .word_i   (s_data_i),
    .data_o   (wr_data_o),
    .last_o   (row_last),
    .full_o   (wr_en_o)
  );

  row_assembler #(.W(HB_W), .DW(DATA_W), .BEATS(HB_BEATS)) u_hbias (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (start_go),
    .beat_i   (accept && (state == ST_HBIAS)),
    .little_i (le_q),
    .word_i   (s_data_i),
    .data_o   (hb_data),
    .last_o   (hb_last),
    .full_o   (hb_full)
  );

  // Load sequencer with registered handshake, status and committed outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      s_ready_o        <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= '0;
      wr_addr_o        <= '0;
      row_idx          <= '0;
      le_q             <= 1'b0;
      hb_valid         <= 1'b0;
      const_sh         <= '0;
      hbias_o          <= '0;
      constant_o       <= '0;
      scaling_factor_o <= SCALING_BIT'(1);
`ifdef MODEL_LOADER_CHECKSUM_EN
      csum_q           <= '0;
      scale_sh         <= '0;
      scale_ok_q       <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state     <= ST_IDLE;
        s_ready_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        if (hb_full) hb_valid <= 1'b1;
`ifdef MODEL_LOADER_CHECKSUM_EN
        if (accept) csum_q <= csum_q ^ s_data_i;
`endif
        unique case (state)
          ST_IDLE: if (start_i) begin
            state     <= ST_WEIGHT;
            s_ready_o <= 1'b1;
            busy_o    <= 1'b1;
            err_o     <= '0;
            le_q      <= little_endian_i;
            row_idx   <= '0;
            hb_valid  <= 1'b0;
`ifdef MODEL_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
          end
          ST_WEIGHT: if (accept && row_last) begin
            wr_addr_o <= row_idx;
            row_idx   <= row_idx + 1'b1;
            if (row_idx == LAST_ROW) state <= ST_HBIAS;
          end
          ST_HBIAS: if (accept && hb_last) state <= ST_CONST;
          ST_CONST: if (accept) begin
            const_sh <= s_data_i[CONST_W-1:0];
            state    <= ST_SCALE;
          end
          ST_SCALE: if (accept) begin
            if (!scale_ok_now) err_o[ERR_SCALE] <= 1'b1;
`ifdef MODEL_LOADER_CHECKSUM_EN
            scale_sh   <= scale_word;
            scale_ok_q <= scale_ok_now;
            state      <= ST_CHECK;
`else
            if (hb_valid) hbias_o <= hb_data;
            constant_o <= const_sh;
            if (scale_ok_now) scaling_factor_o <= scale_word;
            done_o     <= 1'b1;
            s_ready_o  <= 1'b0;
            state      <= ST_DONE;
`endif
          end
`ifdef MODEL_LOADER_CHECKSUM_EN
          ST_CHECK: if (accept) begin
            if (csum_q != s_data_i) err_o[ERR_CSUM] <= 1'b1;
            if (hb_valid) hbias_o <= hb_data;
            constant_o <= const_sh;
            if (scale_ok_q) scaling_factor_o <= scale_sh;
            done_o     <= 1'b1;
            s_ready_o  <= 1'b0;
            state      <= ST_DONE;
          end
`endif
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state     <= ST_IDLE;
            s_ready_o <= 1'b0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_model_stream_loader.sv
// Randomised scoreboard bench for model_stream_loader (small 4-spin configuration).
module tb_model_stream_loader;

  localparam int NS = 4, BJ = 4, BH = 4, DW = 8, CW = 8, SB = 5;
  localparam int ROW_W = NS * BJ, HB_W = NS * BH;
  localparam int RB = ROW_W / DW, HBB = HB_W / DW, AW = $clog2(NS);
`ifdef MODEL_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk_i, rst_i, start_i, abort_i, little_endian_i;
  logic [DW-1:0]     s_data_i;
  logic              s_valid_i, s_ready_o, wr_en_o, busy_o, done_o;
  logic [AW-1:0]     wr_addr_o;
  logic [ROW_W-1:0]  wr_data_o;
  logic [HB_W-1:0]   hbias_o;
  logic [CW-1:0]     constant_o;
  logic [SB-1:0]     scaling_factor_o;
  logic [1:0]        err_o;

  model_stream_loader #(
    .NUM_SPIN(NS), .BITJ(BJ), .BITH(BH), .DATA_W(DW), .CONST_W(CW), .SCALING_BIT(SB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .little_endian_i(little_endian_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .hbias_o(hbias_o), .constant_o(constant_o), .scaling_factor_o(scaling_factor_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [HB_W-1:0] hb;
    logic [CW-1:0]   cst;
    logic [SB-1:0]   scl;
    logic [1:0]      err;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    checks = 0;
  int    errors = 0;

  // Model contents for the next load and the last committed values.
  logic [ROW_W-1:0] m_rows[NS];
  logic [HB_W-1:0]  m_hb;
  logic [CW-1:0]    m_cst;
  logic [DW-1:0]    m_scl_word;
  logic [HB_W-1:0]  cur_hb;
  logic [CW-1:0]    cur_cst;
  logic [SB-1:0]    cur_scl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream word k of a field as the host would send it.
  function automatic logic [DW-1:0] field_word(input logic [ROW_W-1:0] f, input bit le, input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < DW; b++) w[b] = le ? f[k*DW+b] : f[ROW_W-1-(k*DW+b)];
    return w;
  endfunction

  task automatic randomize_model();
    for (int r = 0; r < NS; r++) m_rows[r] = ROW_W'($urandom);
    m_hb       = HB_W'($urandom);
    m_cst      = CW'($urandom);
    m_scl_word = DW'($urandom);
  endtask

  // Present one word, with random idle gaps before it; bounded wait for acceptance.
  task automatic send_word(input logic [DW-1:0] w);
    bit acc;
    int guard;
    while ($urandom_range(0, 3) == 0) begin
      s_valid_i = 1'b0;
      s_data_i  = DW'($urandom);
      @(posedge clk_i); #1;
    end
    s_data_i  = w;
    s_valid_i = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 40) begin
      acc = s_ready_o;
      @(posedge clk_i); #1;
      guard++;
    end
    s_valid_i = 1'b0;
    if (!acc) check("ready_timeout", 64'(acc), 64'(1));
  endtask

  // One load. abort_at < 0: full load; otherwise abort after abort_at beats.
  task automatic run_load(input bit le, input int abort_at, input bit bad_csum);
    logic [DW-1:0] words[$];
    logic [DW-1:0] x;
    logic [SB-1:0] s;
    bit            legal;
    wr_t           ew;
    done_t         ed;
    int            n;
    words = {};
    for (int r = 0; r < NS; r++)
      for (int k = 0; k < RB; k++) words.push_back(field_word(m_rows[r], le, k));
    for (int k = 0; k < HBB; k++) words.push_back(field_word(m_hb, le, k));
    words.push_back(DW'(m_cst));
    words.push_back(m_scl_word);
    if (CSUM_EN) begin
      x = '0;
      foreach (words[i]) x ^= words[i];
      if (bad_csum) x ^= 8'h5A;
      words.push_back(x);
    end
    s     = m_scl_word[SB-1:0];
    legal = (s == 1) || (s == 2) || (s == 4) || (s == 8) || (s == 16);

    for (int r = 0; r < NS; r++) begin
      if (abort_at < 0 || r * RB + RB - 1 < abort_at) begin
        ew.addr = AW'(r);
        ew.data = m_rows[r];
        exp_wr.push_back(ew);
      end
    end
    if (abort_at < 0) begin
      cur_hb  = m_hb;
      cur_cst = m_cst;
      if (legal) cur_scl = s;
      ed.hb  = cur_hb;
      ed.cst = cur_cst;
      ed.scl = cur_scl;
      ed.err = {CSUM_EN && bad_csum, !legal};
      exp_done.push_back(ed);
    end

    start_i = 1'b1;
    little_endian_i = le;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    little_endian_i = 1'($urandom);
    check("start_busy", 64'(busy_o), 64'(1));
    check("start_ready", 64'(s_ready_o), 64'(1));

    n = (abort_at < 0) ? words.size() : abort_at;
    for (int i = 0; i < n; i++) begin
      send_word(words[i]);
      if (i < NS * RB && (i % RB) == RB - 1) begin
        check("wr_en_latency", 64'(wr_en_o), 64'(1));
        check("wr_addr_latency", 64'(wr_addr_o), 64'(i / RB));
      end
    end

    if (abort_at >= 0) begin
      s_valid_i = 1'b1;
      s_data_i  = DW'($urandom);
      abort_i   = 1'b1;
      @(posedge clk_i); #1;
      abort_i   = 1'b0;
      s_valid_i = 1'b0;
      check("abort_busy", 64'(busy_o), 64'(0));
      check("abort_ready", 64'(s_ready_o), 64'(0));
      check("abort_hbias_kept", 64'(hbias_o), 64'(cur_hb));
      check("abort_const_kept", 64'(constant_o), 64'(cur_cst));
      check("abort_scale_kept", 64'(scaling_factor_o), 64'(cur_scl));
      @(posedge clk_i); #1;
      check("abort_no_done", 64'(done_o), 64'(0));
    end else begin
      check("done_latency", 64'(done_o), 64'(1));
      @(posedge clk_i); #1;
      check("done_fall", 64'(done_o), 64'(0));
      check("idle_busy", 64'(busy_o), 64'(0));
      check("idle_ready", 64'(s_ready_o), 64'(0));
    end
  endtask

  // Monitor: compare every write strobe and completion pulse against the scoreboard.
  always @(negedge clk_i) begin
    wr_t   ew;
    done_t ed;
    if (!rst_i) begin
      if (wr_en_o) begin
        check("wr_expected", 64'(exp_wr.size() > 0), 64'(1));
        if (exp_wr.size() > 0) begin
          ew = exp_wr.pop_front();
          check("wr_addr", 64'(wr_addr_o), 64'(ew.addr));
          check("wr_data", 64'(wr_data_o), 64'(ew.data));
        end
      end
      if (done_o) begin
        check("done_expected", 64'(exp_done.size() > 0), 64'(1));
        if (exp_done.size() > 0) begin
          ed = exp_done.pop_front();
          check("hbias", 64'(hbias_o), 64'(ed.hb));
          check("constant", 64'(constant_o), 64'(ed.cst));
          check("scaling", 64'(scaling_factor_o), 64'(ed.scl));
          check("err", 64'(err_o), 64'(ed.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SB-1:0] legal_set[5];
    legal_set = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; little_endian_i = 1'b0;
    s_valid_i = 1'b0; s_data_i = '0;
    cur_hb = '0; cur_cst = '0; cur_scl = SB'(1);
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 64'(s_ready_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_wr_en", 64'(wr_en_o), 64'(0));
    check("rst_scaling", 64'(scaling_factor_o), 64'(1));
    check("rst_hbias", 64'(hbias_o), 64'(0));
    check("rst_const", 64'(constant_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Little order, row 0 = 0x2301, constant -3, scale 8.
    randomize_model();
    m_rows[0] = 16'h2301; m_cst = 8'hFD; m_scl_word = 8'h08;
    run_load(1'b1, -1, 1'b0);
    check("const_minus3", 64'(constant_o), 64'(8'hFD));
    check("scale_8", 64'(scaling_factor_o), 64'(8));

    // Big order, row 0 = 0x0001, scale 4.
    randomize_model();
    m_rows[0] = 16'h0001; m_scl_word = 8'hE4;
    run_load(1'b0, -1, 1'b0);

    // Illegal scale 6: flagged, previous factor kept.
    randomize_model();
    m_scl_word = 8'h06;
    run_load(1'b1, -1, 1'b0);
    check("scale_kept", 64'(scaling_factor_o), 64'(4));
    check("scale_err_flag", 64'(err_o[0]), 64'(1));

    // Abort in the h-bias phase and in the middle of the weights.
    randomize_model();
    run_load(1'($urandom), NS * RB + 1, 1'b0);
    randomize_model();
    run_load(1'b0, 3, 1'b0);

    // Corrupted checksum word (only differs from a clean load when checking is built in).
    randomize_model();
    m_scl_word = 8'h02;
    run_load(1'b1, -1, 1'b1);

    // Random loads: random order, scale, checksum corruption and occasional aborts.
    repeat (14) begin
      randomize_model();
      if ($urandom_range(0, 1) == 0)
        m_scl_word = {3'($urandom), legal_set[$urandom_range(0, 4)]};
      run_load(1'($urandom),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NS * RB + HBB + 1)) : -1,
               1'($urandom));
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
    check("done_queue_drained", 64'(exp_done.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
